cyq_bcd4_counter: RTL
=====================

CYQ_BCD4_COUNTER -- requirements
Module: cyq_bcd4_counter

Interface
REQ-001 The block SHALL have parameter DIV, default 50000, meaning Clk cycles per count step (legal range 2..2^20).
REQ-002 The block SHALL have port Clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port Aclr, input, 1 bit: reset, synchronous, active-high.
REQ-004 The block SHALL have port En, input, 1 bit: count enable; low freezes the prescaler and the count.
REQ-005 The block SHALL have port Up, input, 1 bit: direction, 1 = increment, 0 = decrement.
REQ-006 The block SHALL have port Load, input, 1 bit: synchronous parallel load strobe.
REQ-007 The block SHALL have port Din, input, 16 bits: load value, four BCD nibbles, [15:12] = thousands, [3:0] = units.
REQ-008 The block SHALL have port Q, output, 16 bits: current count, four BCD nibbles, same ordering as Din, feeding the 4-digit display scanner.
REQ-009 The block SHALL have port Tick, output, 1 bit: one-cycle pulse marking a count step.
REQ-010 The block SHALL have port Co, output, 1 bit: one-cycle carry/borrow pulse on wrap.

Function
REQ-011 Prescaler SHALL be a counter P of ceil(log2(DIV)) bits, running 0..DIV-1 and wrapping to 0 while En=1, and holding while En=0.
REQ-012 A step event SHALL occur on the Clk edge where En=1, Load=0, Aclr=0 and P=DIV-1.
REQ-013 On a step with Up=1, units SHALL increment in BCD, and a digit at 9 SHALL go to 0 and carry into the next digit (ripple within one cycle).
REQ-014 On a step with Up=0, units SHALL decrement in BCD, and a digit at 0 SHALL go to 9 and borrow from the next digit.
REQ-015 Up at 9999 SHALL produce 0000 on the step, with Co=1; down at 0000 SHALL produce 9999 on the step, with Co=1.
REQ-016 Tick and Co SHALL be registered and asserted for exactly one Clk cycle, the cycle in which Q first shows the stepped value; Co=1 SHALL imply Tick=1.
REQ-017 Up SHALL be sampled only at the step edge; changes between steps SHALL have no effect on Q.
REQ-018 Load=1 (Aclr=0) SHALL set Q from Din on the next edge, clear P to 0, force Tick=0 and Co=0, and take priority over any simultaneous step.
REQ-019 On load, any Din nibble greater than 9 SHALL load as 0; the other nibbles SHALL load unchanged.
REQ-020 Load SHALL act regardless of En.
REQ-021 Q SHALL hold between steps, and every nibble of Q SHALL always be in 0..9.
REQ-022 Priority SHALL be Aclr > Load > step > hold.

Reset
REQ-023 Aclr=1 on a Clk edge SHALL set Q=16'h0000, P=0, Tick=0 and Co=0, overriding Load and En.
REQ-024 Aclr asserted mid-count (P nonzero) SHALL discard the partial prescale, and counting SHALL restart a full DIV cycles after Aclr deasserts.
REQ-025 No register SHALL depend on power-up value; the block SHALL be defined only after the first Aclr edge.

Verification (DIV=4 for simulation)
REQ-026 Aclr pulse, then En=1, Up=1 for 40 cycles -> Q steps 0000→0001→…→0009→0010 every 4 cycles; Tick high 1 cycle per step; Co=0 throughout.
REQ-027 Load with Din=16'h9998, then En=1, Up=1 -> Q=9999 after 4 cycles, then 0000 with Tick=1 and Co=1 in the same cycle, then Co=0.
REQ-028 Load with Din=16'h0001, then Up=0 -> Q=0000, then 9999 with Co=1; load Din=16'h1000 then one down step -> Q=0999 with Co=0.
REQ-029 Load with Din=16'hA5F3 -> Q=0503; apply Load on the same edge as a pending step (P=3) -> Q=Din value, Tick=0, and the next step occurs 4 cycles later.
REQ-030 En toggled low at P=2 for 10 cycles -> Q and P frozen, no Tick; after re-enable, the step occurs 2 cycles later.
REQ-031 Aclr asserted together with Load=1 while P=2 -> Q=0000, Tick=0, and the first step occurs exactly 4 cycles after Aclr deasserts.

Source files
------------

// File: rtl/cyq_bcd4_counter.sv
// Four-digit BCD up/down counter with a DIV-cycle prescaler, parallel load and
// registered step/wrap pulses. Feeds a 4-digit display scanner via Q.
module cyq_bcd4_counter #(
   parameter int DIV = 50000
) (
   input  logic        Clk,
   input  logic        Aclr,
   input  logic        En,
   input  logic        Up,
   input  logic        Load,
   input  logic [15:0] Din,
   output logic [15:0] Q,
   output logic        Tick,
   output logic        Co
);

   localparam int             P_W   = $clog2(DIV);
   localparam logic [P_W-1:0] P_MAX = P_W'(DIV - 1);

   logic [P_W-1:0] r_p;
   logic [15:0]    r_q;
   logic           r_tick;
   logic           r_co;

   logic           w_step;
   logic           w_carry;
   logic [15:0]    w_q_step;
   logic [15:0]    w_din_bcd;

   assign w_step = En && (r_p == P_MAX);

   // Ripple BCD increment/decrement across all four digits in one cycle;
   // w_carry left set after the top digit means the count wrapped.
   always_comb begin
      w_q_step = r_q;
      w_carry  = 1'b1;
      for (int i = 0; i < 4; i++) begin
         if (w_carry) begin
            if (Up) begin
               if (r_q[4*i +: 4] >= 4'd9) begin
                  w_q_step[4*i +: 4] = 4'd0;
               end else begin
                  w_q_step[4*i +: 4] = r_q[4*i +: 4] + 4'd1;
                  w_carry            = 1'b0;
               end
            end else begin
               if (r_q[4*i +: 4] == 4'd0) begin
                  w_q_step[4*i +: 4] = 4'd9;
               end else begin
                  w_q_step[4*i +: 4] = r_q[4*i +: 4] - 4'd1;
                  w_carry            = 1'b0;
               end
            end
         end
      end
   end

   always_comb begin
      w_din_bcd = Din;
      for (int i = 0; i < 4; i++) begin
         if (Din[4*i +: 4] > 4'd9) w_din_bcd[4*i +: 4] = 4'd0;
      end
   end

   // NOTE: state registers use non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge Clk) begin
      if (Aclr) begin
         r_p    <= '0;
         r_q    <= '0;
         r_tick <= 1'b0;
         r_co   <= 1'b0;
      end else if (Load) begin
         r_p    <= '0;
         r_q    <= w_din_bcd;
         r_tick <= 1'b0;
         r_co   <= 1'b0;
      end else begin
         r_tick <= w_step;
         r_co   <= w_step && w_carry;
         if (En) r_p <= (r_p == P_MAX) ? '0 : r_p + P_W'(1);
         if (w_step) r_q <= w_q_step;
      end
   end

   assign Q    = r_q;
   assign Tick = r_tick;
   assign Co   = r_co;

endmodule
